// File: rtl/npc_ctrl_pkg.sv
// npc_ctrl_pkg: shared types and constants for the NPC control sequencer.
//   state_e   : 3-bit FSM state encoding (also exported on the debug port)
//   opclass_e : opcode class produced by npc_opclass_dec
//   OPC_*     : RV32I major opcodes recognised by the core
//   EBREAK_INST : the only legal SYSTEM instruction
package npc_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_ERR    = 3'd7
    } state_e;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [3:0] {
        CLS_OP_IMM,
        CLS_OP,
        CLS_LOAD,
        CLS_STORE,
        CLS_LUI,
        CLS_AUIPC,
        CLS_JAL,
        CLS_JALR,
        CLS_BRANCH,
        CLS_SYSTEM,
        CLS_ILLEGAL
    } opclass_e;

    localparam logic [31:0] EBREAK_INST = 32'h00100073;

endpackage

// File: rtl/npc_opclass_dec.sv
// npc_opclass_dec: combinational opcode classifier for the instruction register.
//   ir      in  32 : instruction register
//   cls     out    : opcode class (CLS_ILLEGAL for unknown opcodes)
//   illegal out 1  : unknown opcode, or a SYSTEM encoding other than ebreak
//   ebreak  out 1  : ir is exactly the ebreak instruction
module npc_opclass_dec
    import npc_ctrl_pkg::*;
(
    input  logic [31:0] ir,
    output opclass_e    cls,
    output logic        illegal,
    output logic        ebreak
);

    logic [6:0] op;

    assign op = ir[6:0];

    always_comb begin
        cls = op == OPC_OP_IMM ? CLS_OP_IMM :
              op == OPC_OP     ? CLS_OP     :
              op == OPC_LOAD   ? CLS_LOAD   :
              op == OPC_STORE  ? CLS_STORE  :
              op == OPC_LUI    ? CLS_LUI    :
              op == OPC_AUIPC  ? CLS_AUIPC  :
              op == OPC_JAL    ? CLS_JAL    :
              op == OPC_JALR   ? CLS_JALR   :
              op == OPC_BRANCH ? CLS_BRANCH :
              op == OPC_SYSTEM ? CLS_SYSTEM : CLS_ILLEGAL;
    end

    assign ebreak  = ir == EBREAK_INST;
    assign illegal = cls == CLS_ILLEGAL || (cls == CLS_SYSTEM && !ebreak);

endmodule

// File: rtl/npc_ctrl_fsm.sv
// npc_ctrl_fsm: multi-cycle fetch/decode/exec/mem/writeback sequencer of the NPC core.
//   clk, rst (sync, active high), start        : control
//   ifu_req / ifu_rvalid / ifu_inst             : instruction fetch handshake
//   ir                                          : instruction register to the datapath
//   lsu_req / lsu_wen / lsu_ready / lsu_rvalid  : data access handshake
//   rf_wen, pc_wen                              : one-cycle write enables
//   halt, err                                   : sticky stop flags
//   state                                       : debug view of the FSM state
// Optional build macro NPC_CTRL_TIMEOUT_EN adds an 8-bit IFU/LSU watchdog that
// moves to ERR after TIMEOUT_CYCLES wait cycles without the awaited handshake.
module npc_ctrl_fsm
    import npc_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        ifu_req,
    input  logic        ifu_rvalid,
    input  logic [31:0] ifu_inst,
    output logic [31:0] ir,
    output logic        lsu_req,
    output logic        lsu_wen,
    input  logic        lsu_ready,
    input  logic        lsu_rvalid,
    output logic        rf_wen,
    output logic        pc_wen,
    output logic        halt,
    output logic        err,
    output logic [2:0]  state
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..255");
    end

    state_e   st;
    opclass_e cls;
    logic     illegal;
    logic     ebreak;
    logic     is_mem;
    logic     is_store;
    logic     mem_done;
    logic     wd_hit;

    npc_opclass_dec u_dec (
        .ir      (ir),
        .cls     (cls),
        .illegal (illegal),
        .ebreak  (ebreak)
    );

    assign is_store = cls == CLS_STORE;
    assign is_mem   = cls == CLS_LOAD || is_store;
    // Before lsu_ready the request is still open, so rvalid only counts together
    // with ready; afterwards rvalid alone completes the access.
    assign mem_done = lsu_req ? lsu_ready && lsu_rvalid : lsu_rvalid;
    assign state    = st;

`ifdef NPC_CTRL_TIMEOUT_EN
    logic [7:0] wd;

    // Every entry into FETCH/MEM comes from a non-wait state, so clearing outside
    // those states is the same as clearing on entry. Saturates to avoid wrap.
    always_ff @(posedge clk) begin
        if (rst || !(st == S_FETCH || st == S_MEM))
            wd <= '0;
        else if (wd != 8'hFF)
            wd <= wd + 8'd1;
    end

    assign wd_hit = wd >= 8'(TIMEOUT_CYCLES - 1);
`else
    assign wd_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            st      <= S_IDLE;
            ir      <= '0;
            ifu_req <= 1'b0;
            lsu_req <= 1'b0;
            lsu_wen <= 1'b0;
            rf_wen  <= 1'b0;
            pc_wen  <= 1'b0;
            halt    <= 1'b0;
            err     <= 1'b0;
        end else begin
            rf_wen <= 1'b0;
            pc_wen <= 1'b0;
            case (st)
                S_IDLE: begin
                    if (start) begin
                        st      <= S_FETCH;
                        ifu_req <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (ifu_rvalid) begin
                        ir      <= ifu_inst;
                        ifu_req <= 1'b0;
                        st      <= S_DECODE;
                    end else if (wd_hit) begin
                        ifu_req <= 1'b0;
                        err     <= 1'b1;
                        st      <= S_ERR;
                    end
                end
                S_DECODE: begin
                    if (illegal) begin
                        err <= 1'b1;
                        st  <= S_ERR;
                    end else if (ebreak) begin
                        halt   <= 1'b1;
                        pc_wen <= 1'b1;
                        st     <= S_HALT;
                    end else begin
                        st <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (is_mem) begin
                        lsu_req <= 1'b1;
                        lsu_wen <= is_store;
                        st      <= S_MEM;
                    end else begin
                        pc_wen <= 1'b1;
                        rf_wen <= cls != CLS_BRANCH;
                        st     <= S_WB;
                    end
                end
                S_MEM: begin
                    if (mem_done) begin
                        lsu_req <= 1'b0;
                        lsu_wen <= 1'b0;
                        pc_wen  <= 1'b1;
                        rf_wen  <= !is_store;
                        st      <= S_WB;
                    end else if (lsu_req && lsu_ready) begin
                        lsu_req <= 1'b0;
                        lsu_wen <= 1'b0;
                    end else if (wd_hit) begin
                        lsu_req <= 1'b0;
                        lsu_wen <= 1'b0;
                        err     <= 1'b1;
                        st      <= S_ERR;
                    end
                end
                S_WB: begin
                    ifu_req <= 1'b1;
                    st      <= S_FETCH;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_npc_ctrl_fsm.sv
// tb_npc_ctrl_fsm: directed plus randomized bench for npc_ctrl_fsm with an
// instruction-level reference model (expected class, latency and enables).
module tb_npc_ctrl_fsm;

`ifdef NPC_CTRL_TIMEOUT_EN
    localparam int TO = 4;
`else
    localparam int TO = 255;
`endif

    localparam int K_ALU = 0, K_LOAD = 1, K_STORE = 2, K_BR = 3, K_EBRK = 4, K_ILL = 5;

    localparam logic [6:0] ALU_OPS [6] = '{7'b0010011, 7'b0110011, 7'b0110111,
                                           7'b0010111, 7'b1101111, 7'b1100111};
    localparam logic [6:0] LEGAL_OPS [9] = '{7'b0010011, 7'b0110011, 7'b0110111,
                                             7'b0010111, 7'b1101111, 7'b1100111,
                                             7'b0000011, 7'b0100011, 7'b1100011};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        ifu_req;
    logic        ifu_rvalid = 1'b0;
    logic [31:0] ifu_inst = '0;
    logic [31:0] ir;
    logic        lsu_req;
    logic        lsu_wen;
    logic        lsu_ready = 1'b0;
    logic        lsu_rvalid = 1'b0;
    logic        rf_wen;
    logic        pc_wen;
    logic        halt;
    logic        err;
    logic [2:0]  state;

    int checks = 0;
    int errors = 0;

    npc_ctrl_fsm #(.TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .ifu_req    (ifu_req),
        .ifu_rvalid (ifu_rvalid),
        .ifu_inst   (ifu_inst),
        .ir         (ir),
        .lsu_req    (lsu_req),
        .lsu_wen    (lsu_wen),
        .lsu_ready  (lsu_ready),
        .lsu_rvalid (lsu_rvalid),
        .rf_wen     (rf_wen),
        .pc_wen     (pc_wen),
        .halt       (halt),
        .err        (err),
        .state      (state)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench time limit reached");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int kind(input logic [31:0] w);
        logic [6:0] op;
        op = w[6:0];
        if (w == 32'h00100073) return K_EBRK;
        if (op == 7'b1110011) return K_ILL;
        if (op == 7'b0000011) return K_LOAD;
        if (op == 7'b0100011) return K_STORE;
        if (op == 7'b1100011) return K_BR;
        foreach (ALU_OPS[i]) if (op == ALU_OPS[i]) return K_ALU;
        return K_ILL;
    endfunction

    task automatic chk_reset(input string tag);
        chk({tag, "_state"}, 32'(state), 0);
        chk({tag, "_ir"}, ir, 0);
        chk({tag, "_outs"}, 32'({ifu_req, lsu_req, lsu_wen, rf_wen, pc_wen, halt, err}), 0);
    endtask

    task automatic restart;
        rst = 1'b1;
        tick;
        chk_reset("reset");
        rst = 1'b0;
        start = 1'b1;
        tick;
        start = 1'b0;
        chk("start_state", 32'(state), 1);
        chk("start_ifu_req", 32'(ifu_req), 1);
    endtask

    // Expects to be called in the first FETCH cycle; leaves the DUT in the next
    // FETCH cycle for ordinary instructions, or in HALT/ERR.
    task automatic run_inst(input logic [31:0] w, input int fd, input int rd, input int vd,
                            input bit same);
        int  k;
        int  lat;
        int  n;
        bit  mem;
        k   = kind(w);
        mem = k == K_LOAD || k == K_STORE;
        lat = 4 + fd + (mem ? 1 + rd + (same ? 0 : 1 + vd) : 0);
        n   = 1;
        for (int i = 0; i < fd; i++) begin
            chk("fetch_wait_req", 32'(ifu_req), 1);
            chk("fetch_wait_state", 32'(state), 1);
            ifu_rvalid = 1'b0;
            ifu_inst   = $urandom;
            lsu_rvalid = 1'($urandom);
            start      = 1'($urandom);
            tick;
            n++;
        end
        chk("fetch_req", 32'(ifu_req), 1);
        lsu_rvalid = 1'b0;
        start      = 1'b0;
        ifu_rvalid = 1'b1;
        ifu_inst   = w;
        tick;
        n++;
        ifu_rvalid = 1'b0;
        ifu_inst   = $urandom;
        chk("decode_state", 32'(state), 2);
        chk("decode_ir", ir, w);
        chk("decode_ifu_req", 32'(ifu_req), 0);
        tick;
        if (k == K_ILL) begin
            chk("err_flag", 32'(err), 1);
            chk("err_state", 32'(state), 7);
            chk("err_no_wb", 32'({pc_wen, rf_wen, halt}), 0);
            tick;
            chk("err_sticky", 32'({err, state}), 32'({1'b1, 3'd7}));
            chk("err_no_pc", 32'(pc_wen), 0);
            return;
        end
        if (k == K_EBRK) begin
            chk("halt_flag", 32'(halt), 1);
            chk("halt_state", 32'(state), 6);
            chk("halt_pc_wen", 32'(pc_wen), 1);
            chk("halt_no_err", 32'({err, rf_wen}), 0);
            ifu_rvalid = 1'b1;
            ifu_inst   = $urandom;
            tick;
            ifu_rvalid = 1'b0;
            chk("halt_ir_kept", ir, w);
            chk("halt_sticky", 32'({halt, state}), 32'({1'b1, 3'd6}));
            chk("halt_pc_once", 32'(pc_wen), 0);
            return;
        end
        n++;
        chk("exec_state", 32'(state), 3);
        chk("exec_no_wen", 32'({pc_wen, rf_wen}), 0);
        tick;
        n++;
        if (mem) begin
            for (int i = 0; i < rd; i++) begin
                chk("mem_stall_req", 32'(lsu_req), 1);
                chk("mem_stall_wen", 32'(lsu_wen), 32'(k == K_STORE));
                chk("mem_stall_state", 32'(state), 4);
                lsu_ready  = 1'b0;
                lsu_rvalid = 1'($urandom);
                tick;
                n++;
            end
            chk("mem_req", 32'(lsu_req), 1);
            chk("mem_wen", 32'(lsu_wen), 32'(k == K_STORE));
            lsu_ready  = 1'b1;
            lsu_rvalid = same;
            tick;
            n++;
            lsu_ready  = 1'b0;
            lsu_rvalid = 1'b0;
            if (!same) begin
                chk("mem_req_drop", 32'({lsu_req, lsu_wen}), 0);
                chk("mem_wait_state", 32'(state), 4);
                for (int i = 0; i < vd; i++) begin
                    tick;
                    n++;
                    chk("mem_rwait_state", 32'(state), 4);
                end
                lsu_rvalid = 1'b1;
                tick;
                n++;
                lsu_rvalid = 1'b0;
            end
        end
        chk("wb_state", 32'(state), 5);
        chk("wb_latency", n, lat);
        chk("wb_pc_wen", 32'(pc_wen), 1);
        chk("wb_rf_wen", 32'(rf_wen), 32'(!(k == K_STORE || k == K_BR)));
        chk("wb_lsu_idle", 32'(lsu_req), 0);
        tick;
        chk("next_fetch", 32'({state, ifu_req}), 32'({3'd1, 1'b1}));
        chk("next_no_wen", 32'({pc_wen, rf_wen}), 0);
    endtask

    initial begin
        logic [31:0] w;
        int          rd;
        tick;
        tick;
        chk_reset("por");
        rst = 1'b0;
        tick;
        chk("idle_hold", 32'(state), 0);
        start = 1'b1;
        tick;
        start = 1'b0;
        chk("first_fetch", 32'({state, ifu_req}), 32'({3'd1, 1'b1}));

        run_inst(32'h00500093, 0, 0, 0, 1'b0);
        run_inst(32'h00112023, 0, 2, 0, 1'b0);
        run_inst(32'h00002083, 0, 0, 0, 1'b1);

        for (int i = 0; i < 40; i++) begin
            w  = $urandom;
            w  = {w[31:7], LEGAL_OPS[$urandom_range(0, 8)]};
            rd = $urandom_range(0, 2);
            run_inst(w, $urandom_range(0, 3), rd, $urandom_range(0, 2 - rd), 1'($urandom));
        end

        restart;
        ifu_rvalid = 1'b1;
        ifu_inst   = 32'h00002083;
        tick;
        ifu_rvalid = 1'b0;
        tick;
        tick;
        chk("abort_mem_req", 32'(lsu_req), 1);
        rst = 1'b1;
        tick;
        chk("abort_req_drop", 32'(lsu_req), 0);
        chk_reset("abort");

        restart;
        run_inst(32'hFFFFFFFF, 1, 0, 0, 1'b0);
        restart;
        run_inst(32'h00100073, 0, 0, 0, 1'b0);
        restart;
        run_inst(32'h00000073, 2, 0, 0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            restart;
            w = $urandom;
            run_inst(w, $urandom_range(0, 2), 1, 0, 1'b1);
        end

        restart;
`ifdef NPC_CTRL_TIMEOUT_EN
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("wd_fetch_wait", 32'({state, err}), 32'({3'd1, 1'b0}));
        end
        tick;
        chk("wd_err", 32'({state, err}), 32'({3'd7, 1'b1}));
        chk("wd_req_drop", 32'(ifu_req), 0);
`else
        repeat (1000) tick;
        chk("no_wd_fetch", 32'({state, ifu_req, err}), 32'({3'd1, 1'b1, 1'b0}));
`endif
        rst = 1'b1;
        tick;
        chk_reset("final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
